reg_two_wr_sequencer: RTL and testbench

//  Upstream write sequencer for a two-write-port register (port A has

---
 rtl/reg_two_wr_sequencer_if.sv | 30 +++
 rtl/reg_two_wr_sequencer.sv | 87 ++++++++
 tb/tb_reg_two_wr_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_two_wr_sequencer_if.sv
// Write-stream and register-port bundle for reg_two_wr_sequencer.
// The master drives the two valid/data streams. The slave answers with ready, the register writes and the stall count.
interface reg_two_wr_sequencer_if #(
  parameter int unsigned width     = 1,
  parameter int unsigned max_stall = 4
);
  localparam int unsigned SW = $clog2(max_stall + 1);

  logic             a_valid;
  logic [width-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [width-1:0] b_data;
  logic             b_ready;
  logic             ena;
  logic [width-1:0] d_ina;
  logic             enb;
  logic [width-1:0] d_inb;
  logic [SW-1:0]    stall;

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready, ena, d_ina, enb, d_inb, stall
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready, ena, d_ina, enb, d_inb, stall
  );
endinterface

// File: rtl/reg_two_wr_sequencer.sv
// Buffers two write streams and issues at most one register write per cycle.
// A has priority. A bounded stall counter guarantees that B is eventually served.
module reg_two_wr_sequencer #(
  parameter int unsigned width     = 1,
  parameter int unsigned depth     = 2,
  parameter int unsigned max_stall = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_two_wr_sequencer_if.slave  bus
);
  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = $clog2(max_stall + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(max_stall);

  logic [width-1:0] mem_a_q [depth];
  logic [width-1:0] mem_b_q [depth];
  logic [PW-1:0]    wr_a_q, rd_a_q, wr_b_q, rd_b_q;
  logic [PW-1:0]    wr_a_d, rd_a_d, wr_b_d, rd_b_d;
  logic             rdy_a_q, rdy_b_q, rdy_a_d, rdy_b_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic             empty_a, empty_b;
  logic             push_a, push_b;
  logic             grant_a, grant_b;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  function automatic logic is_full(logic [PW-1:0] wr, logic [PW-1:0] rd);
    return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  // Grant, pointer and stall next-state, all derived from registered state.
  always_comb begin
    empty_a = (wr_a_q == rd_a_q);
    empty_b = (wr_b_q == rd_b_q);
    push_a  = bus.a_valid && rdy_a_q;
    push_b  = bus.b_valid && rdy_b_q;
    grant_a = !empty_a && (empty_b || (stall_q < STALL_MAX));
    grant_b = !empty_b && (empty_a || (stall_q == STALL_MAX));

    wr_a_d  = wr_a_q + PW'(push_a);
    rd_a_d  = rd_a_q + PW'(grant_a);
    wr_b_d  = wr_b_q + PW'(push_b);
    rd_b_d  = rd_b_q + PW'(grant_b);
    rdy_a_d = !is_full(wr_a_d, rd_a_d);
    rdy_b_d = !is_full(wr_b_d, rd_b_d);

    stall_d = '0;
    if (grant_a && !empty_b) begin
      stall_d = (stall_q == STALL_MAX) ? STALL_MAX : stall_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_a_q  <= '0;
      rd_a_q  <= '0;
      wr_b_q  <= '0;
      rd_b_q  <= '0;
      rdy_a_q <= 1'b0;
      rdy_b_q <= 1'b0;
      stall_q <= '0;
    end else begin
      wr_a_q  <= wr_a_d;
      rd_a_q  <= rd_a_d;
      wr_b_q  <= wr_b_d;
      rd_b_q  <= rd_b_d;
      rdy_a_q <= rdy_a_d;
      rdy_b_q <= rdy_b_d;
      stall_q <= stall_d;
    end
  end

  // Storage needs no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_a) mem_a_q[wr_a_q[AW-1:0]] <= bus.a_data;
    if (push_b) mem_b_q[wr_b_q[AW-1:0]] <= bus.b_data;
  end

  assign bus.a_ready = rdy_a_q;
  assign bus.b_ready = rdy_b_q;
  assign bus.ena     = grant_a;
  assign bus.enb     = grant_b;
  assign bus.d_ina   = grant_a ? mem_a_q[rd_a_q[AW-1:0]] : '0;
  assign bus.d_inb   = grant_b ? mem_b_q[rd_b_q[AW-1:0]] : '0;
  assign bus.stall   = stall_q;
endmodule

// File: tb/tb_reg_two_wr_sequencer.sv
// Scoreboard bench for reg_two_wr_sequencer: a queue-based reference model predicts each register write.
// A negedge monitor compares the predictions with what the DUT presents.
module tb_reg_two_wr_sequencer;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned MS = 4;

  typedef struct {
    int             cyc;
    bit             pb;
    logic [W-1:0]   data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_two_wr_sequencer_if #(.width(W), .max_stall(MS)) bus ();

  reg_two_wr_sequencer #(.width(W), .depth(D), .max_stall(MS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  exp_t         exp_q[$];
  int           stall_m;
  bit           rdy_a_m, rdy_b_m;
  bit           gnt_valid, gnt_b;
  bit           a_took, b_took;
  int           cyc;
  int           total, bad;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: one posedge = serve the chosen write, accept inputs, then pick the next winner.
  function automatic void model_step();
    logic [W-1:0] d;
    if (gnt_valid && !gnt_b && qb.size() != 0) stall_m = (stall_m < int'(MS)) ? stall_m + 1 : int'(MS);
    else stall_m = 0;
    if (gnt_valid && !gnt_b) void'(qa.pop_front());
    if (gnt_valid && gnt_b)  void'(qb.pop_front());
    a_took = bus.a_valid && rdy_a_m;
    b_took = bus.b_valid && rdy_b_m;
    if (a_took) qa.push_back(bus.a_data);
    if (b_took) qb.push_back(bus.b_data);
    rdy_a_m = qa.size() < int'(D);
    rdy_b_m = qb.size() < int'(D);
    cyc++;
    gnt_valid = 1'b0;
    gnt_b     = 1'b0;
    if (qa.size() != 0 && (qb.size() == 0 || stall_m < int'(MS))) gnt_valid = 1'b1;
    else if (qb.size() != 0) begin
      gnt_valid = 1'b1;
      gnt_b     = 1'b1;
    end
    if (gnt_valid) begin
      d = gnt_b ? qb[0] : qa[0];
      exp_q.push_back('{cyc, gnt_b, d});
    end
  endfunction

  function automatic void model_clear();
    qa.delete();
    qb.delete();
    exp_q.delete();
    stall_m   = 0;
    rdy_a_m   = 1'b0;
    rdy_b_m   = 1'b0;
    gnt_valid = 1'b0;
    gnt_b     = 1'b0;
    a_took    = 1'b0;
    b_took    = 1'b0;
  endfunction

  function automatic void monitor_step();
    exp_t e;
    check("excl_en", 64'(bus.ena && bus.enb), 64'(0));
    check("a_ready", 64'(bus.a_ready), 64'(rdy_a_m));
    check("b_ready", 64'(bus.b_ready), 64'(rdy_b_m));
    check("stall", 64'(bus.stall), 64'(stall_m));
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missed_write: got none expected port%s data %0h (cycle %0d)",
               e.pb ? "B" : "A", e.data, e.cyc);
    end
    if (bus.ena || bus.enb) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got ena=%0b enb=%0b expected no write (cycle %0d)",
                 bus.ena, bus.enb, cyc);
      end else begin
        e = exp_q.pop_front();
        check("write_port", 64'(bus.enb), 64'(e.pb));
        check("write_data", 64'(e.pb ? bus.d_inb : bus.d_ina), 64'(e.data));
        check("other_data", 64'(e.pb ? bus.d_ina : bus.d_inb), 64'(0));
      end
    end else begin
      check("idle_data", 64'({bus.d_ina, bus.d_inb}), 64'(0));
    end
  endfunction

  // Randomised driver; a valid that was not accepted is held with its data.
  task automatic run(int n, int a_pct, int b_pct, int b_left, bit t5);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (t5 && i == 2) check("t5_b_ready_low", 64'(bus.b_ready), 64'(0));
      if (t5 && i == 6) check("t5_b_ready_back", 64'(bus.b_ready), 64'(1));
      if (!(bus.a_valid && !a_took)) begin
        bus.a_valid = ($urandom_range(0, 99) < a_pct);
        bus.a_data  = W'($urandom);
      end
      if (!(bus.b_valid && !b_took)) begin
        if (b_left == 0) bus.b_valid = 1'b0;
        else begin
          bus.b_valid = ($urandom_range(0, 99) < b_pct);
          bus.b_data  = W'($urandom);
          if (bus.b_valid && b_left > 0) b_left--;
        end
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
    end
  endtask

  initial begin
    bus.a_valid = 1'b0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_data  = '0;
    total = 0;
    bad   = 0;
    cyc   = 0;
    model_clear();

    fork
      forever begin @(posedge clk); if (rst_n) model_step(); end
      forever begin @(negedge clk); monitor_step(); end
      forever begin @(negedge rst_n); model_clear(); end
    join_none

    // Reset state
    @(negedge clk);
    check("rst_ena", 64'(bus.ena), 64'(0));
    check("rst_enb", 64'(bus.enb), 64'(0));
    check("rst_d_in", 64'({bus.d_ina, bus.d_inb}), 64'(0));
    check("rst_ready", 64'({bus.a_ready, bus.b_ready}), 64'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'({bus.a_ready, bus.b_ready}), 64'(2'b11));
    check("post_rst_stall", 64'(bus.stall), 64'(0));

    // Single A write: latency one cycle, then idle
    bus.a_valid = 1'b1;
    bus.a_data  = 8'h5A;
    @(negedge clk);
    bus.a_valid = 1'b0;
    check("t2_ena", 64'({bus.ena, bus.d_ina, bus.enb}), 64'({1'b1, 8'h5A, 1'b0}));
    @(negedge clk);
    check("t2_ena_off", 64'(bus.ena), 64'(0));

    // A and B together: A first, B next
    bus.a_valid = 1'b1;
    bus.a_data  = 8'h11;
    bus.b_valid = 1'b1;
    bus.b_data  = 8'h22;
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    check("t3_first", 64'({bus.ena, bus.d_ina, bus.enb}), 64'({1'b1, 8'h11, 1'b0}));
    @(negedge clk);
    check("t3_second", 64'({bus.enb, bus.d_inb, bus.ena}), 64'({1'b1, 8'h22, 1'b0}));
    idle(2);

    // A streams, one B waits: four A grants, then B
    bus.a_valid = 1'b1;
    bus.a_data  = W'($urandom);
    bus.b_valid = 1'b1;
    bus.b_data  = 8'h44;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.b_valid = 1'b0;
      bus.a_data  = W'($urandom);
      check("t4_enb", 64'(bus.enb), 64'(k == 5));
      if (k == 5) check("t4_d_inb", 64'(bus.d_inb), 64'(8'h44));
    end
    @(negedge clk);
    bus.a_valid = 1'b0;
    check("t4_stall_clr", 64'(bus.stall), 64'(0));
    idle(4);

    // B backpressure with A always busy
    run(12, 100, 100, 3, 1'b1);
    idle(12);

    // Fill both FIFOs, then reset between edges
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.a_data = W'($urandom);
      bus.b_data = W'($urandom);
      @(negedge clk);
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(posedge clk);
    #1 check("t6_busy", 64'(bus.ena || bus.enb), 64'(1));
    #1 rst_n = 1'b0;
    #1 check("t6_async_en", 64'({bus.ena, bus.enb}), 64'(0));
    check("t6_async_data", 64'({bus.d_ina, bus.d_inb}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(6);
    check("t6_no_write", 64'({bus.ena, bus.enb}), 64'(0));

    // Random traffic at several load levels
    run(300, 50, 40, -1, 1'b0);
    run(300, 95, 95, -1, 1'b0);
    run(200, 20, 80, -1, 1'b0);
    idle(12);
    check("drain_exp", 64'(exp_q.size()), 64'(0));
    check("drain_model", 64'(qa.size() + qb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
